sign_div: RTL and testbench

- Sequential signed integer divider; the inverse of the team's shift-add signed multiplier.
- Divides a 2N-bit signed dividend by an N-bit signed divisor, producing an N-bit quotient and an N-bit remainder.
- Uses the same start/valid handshake as the multiplier, so a product can be checked by dividing it back.
- Restoring algorithm on magnitudes, one quotient bit per clock, with sign fix-up at the end.

---
 rtl/sign_div.sv | 164 ++++++++++++++++
 tb/tb_sign_div.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sign_div.sv
// sign_div: sequential signed integer divider (restoring, one quotient bit per clock).
//
// Divides a 2N-bit signed dividend X by an N-bit signed divisor Y and gives an
// N-bit quotient Q and an N-bit remainder R. Division truncates toward zero, and
// the remainder takes the sign of the dividend. The core works on unsigned
// magnitudes, and the signs are applied once all 2N quotient bits are known.
//
// Ports:
//   clk    - system clock, rising edge
//   rst    - asynchronous reset, active low
//   start  - request; sampled only while idle
//   X      - 2N-bit signed dividend
//   Y      - N-bit signed divisor
//   Q      - N-bit signed quotient (registered)
//   R      - N-bit signed remainder (registered)
//   dz     - divide-by-zero flag (registered)
//   ovf    - quotient does not fit in N signed bits (registered)
//   valid  - result valid, held high until start is dropped (registered)
module sign_div #(
    parameter int N = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [2*N-1:0] X,
    input  logic [N-1:0]   Y,
    output logic [N-1:0]   Q,
    output logic [N-1:0]   R,
    output logic           dz,
    output logic           ovf,
    output logic           valid
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    localparam int CW = $clog2(2*N+1);

    // Largest quotient magnitudes that still fit in N signed bits.
    localparam logic [2*N-1:0] NEG_LIMIT = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
    localparam logic [2*N-1:0] POS_LIMIT = {{(N+1){1'b0}}, {(N-1){1'b1}}};

    state_t state, next_state;

    logic [CW-1:0]  cnt;
    logic [2*N-1:0] dvd;
    logic [2*N-1:0] quo;
    logic [N-1:0]   dvs;
    logic [N-1:0]   rem;
    logic           sx;
    logic           sy;
    logic           zero;

    logic [2*N-1:0] abs_x;
    logic [N-1:0]   abs_y;
    logic [N:0]     shifted;
    logic [N:0]     diff;
    logic           fits;
    logic           neg;
    logic           q_ovf;
    logic [N-1:0]   q_fix;
    logic [N-1:0]   r_fix;

    // Magnitudes are taken modulo 2^W, so the most negative operands map onto
    // their true unsigned magnitude (e.g. -128 -> 8'h80) without wrapping.
    assign abs_x = X[2*N-1] ? -X : X;
    assign abs_y = Y[N-1]   ? -Y : Y;

    // The partial remainder is always below the divisor, so after the shift it
    // fits in N+1 bits. The trial difference's top bit is the borrow: clear
    // means the divisor fitted and this quotient bit is a 1.
    assign shifted = {rem, dvd[2*N-1]};
    assign diff    = shifted - {1'b0, dvs};
    assign fits    = ~diff[N];

    // Sign fix-up and range check applied on the finishing CALC cycle.
    assign neg   = sx ^ sy;
    assign q_ovf = neg ? (quo > NEG_LIMIT) : (quo > POS_LIMIT);
    assign q_fix = neg ? -quo[N-1:0] : quo[N-1:0];
    assign r_fix = sx  ? -rem : rem;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A zero divisor still passes through CALC, but with the
    // counter loaded to zero, so it finishes on the very next edge.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start)      next_state = CALC;
            CALC: if (cnt == '0)  next_state = DONE;
            DONE: if (!start)     next_state = IDLE;
            default:              next_state = IDLE;
        endcase
    end

    // Datapath: operand capture, the restoring iterations, and result
    // registration. Results stay on Q/R/flags until a later operation
    // finishes and overwrites them.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt   <= '0;
            dvd   <= '0;
            quo   <= '0;
            dvs   <= '0;
            rem   <= '0;
            sx    <= 1'b0;
            sy    <= 1'b0;
            zero  <= 1'b0;
            Q     <= '0;
            R     <= '0;
            dz    <= 1'b0;
            ovf   <= 1'b0;
            valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd  <= abs_x;
                        dvs  <= abs_y;
                        sx   <= X[2*N-1];
                        sy   <= Y[N-1];
                        rem  <= '0;
                        quo  <= '0;
                        zero <= (Y == '0);
                        cnt  <= (Y == '0) ? '0 : CW'(2*N);
                    end
                end
                CALC: begin
                    if (cnt != '0) begin
                        rem <= fits ? diff[N-1:0] : shifted[N-1:0];
                        quo <= {quo[2*N-2:0], fits};
                        dvd <= {dvd[2*N-2:0], 1'b0};
                        cnt <= cnt - CW'(1);
                    end else begin
                        Q     <= q_ovf ? '0 : q_fix;
                        R     <= q_ovf ? '0 : r_fix;
                        ovf   <= q_ovf;
                        dz    <= zero;
                        valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!start) begin
                        valid <= 1'b0;
                    end
                end
                default: begin
                    valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sign_div.sv
// tb_sign_div: self-checking bench for sign_div (N = 8).
//
// A behavioural model predicts each result with plain signed integer division
// and tracks when it should appear. A compare process checks every output
// against the model on each falling clock edge. Directed cases also pin
// hand-computed values and latencies.
module tb_sign_div;

    localparam int N = 8;

    typedef struct packed {
        logic [7:0] q;
        logic [7:0] r;
        logic       d;
        logic       o;
    } res_t;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        start = 1'b0;
    logic [15:0] X     = '0;
    logic [7:0]  Y     = '0;
    logic [7:0]  Q;
    logic [7:0]  R;
    logic        dz;
    logic        ovf;
    logic        valid;

    int total = 0;
    int bad   = 0;
    bit cmp_on = 1'b0;

    sign_div #(.N(N)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .X     (X),
        .Y     (Y),
        .Q     (Q),
        .R     (R),
        .dz    (dz),
        .ovf   (ovf),
        .valid (valid)
    );

    always #5 clk = ~clk;

    // Reference result from plain integer arithmetic. The / operator truncates
    // toward zero, and % takes the sign of the dividend.
    function automatic res_t predict(input logic [15:0] x, input logic [7:0] y);
        res_t   res;
        longint xs;
        longint ys;
        longint qq;
        longint rr;
        res = '0;
        xs  = longint'($signed(x));
        ys  = longint'($signed(y));
        if (ys == 0) begin
            res.d = 1'b1;
        end else begin
            qq = xs / ys;
            rr = xs % ys;
            if (qq > 127 || qq < -128) begin
                res.o = 1'b1;
            end else begin
                res.q = qq[7:0];
                res.r = rr[7:0];
            end
        end
        return res;
    endfunction

    // Timing model: a request seen while idle produces its result 17 edges
    // later (1 edge for a zero divisor). The result then stays visible until
    // start is seen low.
    res_t pend   = '0;
    res_t shown  = '0;
    logic mvalid = 1'b0;
    int   mcnt   = 0;
    bit   mbusy  = 1'b0;
    bit   mdone  = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            shown  <= '0;
            mvalid <= 1'b0;
            mcnt   <= 0;
            mbusy  <= 1'b0;
            mdone  <= 1'b0;
        end else if (mbusy) begin
            mcnt <= mcnt - 1;
            if (mcnt == 1) begin
                shown  <= pend;
                mvalid <= 1'b1;
                mbusy  <= 1'b0;
                mdone  <= 1'b1;
            end
        end else if (mdone) begin
            if (!start) begin
                mvalid <= 1'b0;
                mdone  <= 1'b0;
            end
        end else if (start) begin
            pend  <= predict(X, Y);
            mcnt  <= (Y == 8'h00) ? 1 : 17;
            mbusy <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Continuous comparison against the model.
    always @(negedge clk) begin
        if (cmp_on) begin
            check("model valid", 16'(valid), 16'(mvalid));
            check("model Q",     16'(Q),     16'(shown.q));
            check("model R",     16'(R),     16'(shown.r));
            check("model dz",    16'(dz),    16'(shown.d));
            check("model ovf",   16'(ovf),   16'(shown.o));
        end
    end

    task automatic checkOutput(input string name, input logic [7:0] eq, input logic [7:0] er,
                               input logic edz, input logic eovf);
        check({name, " valid"}, 16'(valid), 16'd1);
        check({name, " Q"},     16'(Q),     16'(eq));
        check({name, " R"},     16'(R),     16'(er));
        check({name, " dz"},    16'(dz),    16'(edz));
        check({name, " ovf"},   16'(ovf),   16'(eovf));
    endtask

    // Pulse reset away from clock edges, confirming the outputs clear at once.
    task automatic pulseReset();
        @(negedge clk);
        #2;
        start = 1'b0;
        rst   = 1'b0;
        #1;
        check("reset Q",     16'(Q),     16'd0);
        check("reset R",     16'(R),     16'd0);
        check("reset dz",    16'(dz),    16'd0);
        check("reset ovf",   16'(ovf),   16'd0);
        check("reset valid", 16'(valid), 16'd0);
        cmp_on = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    // Present operands with start high and count edges until valid rises.
    // glitch_at > 0 scrambles X/Y that many edges after the start edge.
    task automatic applyStimulus(input string name, input logic [15:0] x, input logic [7:0] y,
                                 input int explat, input int glitch_at);
        int lat;
        @(negedge clk);
        X     = x;
        Y     = y;
        start = 1'b1;
        @(posedge clk);
        #1;
        lat = 0;
        while (!valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
            if (lat == glitch_at) begin
                X = 16'($urandom);
                Y = 8'($urandom);
            end
        end
        check({name, " latency"}, 16'(lat), 16'(explat));
    endtask

    task automatic dropStart(input string name);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        check({name, " valid drop"}, 16'(valid), 16'd0);
    endtask

    initial begin
        logic [15:0] rx;
        logic [7:0]  ry;

        // 1: basic division with start held high.
        pulseReset();
        applyStimulus("t1", 16'h0438, 8'h0C, 17, 0);
        checkOutput("t1", 8'h5A, 8'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("t1 valid held", 16'(valid), 16'd1);
        dropStart("t1");

        // 2: signs and truncation.
        pulseReset();
        applyStimulus("t2a", 16'h0384, 8'h0F, 17, 0);
        checkOutput("t2a", 8'h3C, 8'h00, 1'b0, 1'b0);
        dropStart("t2a");
        applyStimulus("t2b", 16'hFFDB, 8'h07, 17, 0);
        checkOutput("t2b", 8'hFB, 8'hFE, 1'b0, 1'b0);
        dropStart("t2b");
        applyStimulus("t2c", 16'h0025, 8'hF9, 17, 0);
        checkOutput("t2c", 8'hFB, 8'h02, 1'b0, 1'b0);
        dropStart("t2c");

        // 3: boundaries.
        applyStimulus("t3a", 16'h4000, 8'h80, 17, 0);
        checkOutput("t3a", 8'h80, 8'h00, 1'b0, 1'b0);
        dropStart("t3a");
        applyStimulus("t3b", 16'h8000, 8'hFF, 17, 0);
        checkOutput("t3b", 8'h00, 8'h00, 1'b0, 1'b1);
        dropStart("t3b");
        applyStimulus("t3c", 16'h0080, 8'h01, 17, 0);
        checkOutput("t3c", 8'h00, 8'h00, 1'b0, 1'b1);
        dropStart("t3c");

        // 4: divide by zero.
        applyStimulus("t4", 16'd100, 8'h00, 1, 0);
        checkOutput("t4", 8'h00, 8'h00, 1'b1, 1'b0);
        dropStart("t4");

        // 5: reset in the middle of an operation, then a clean restart.
        @(negedge clk);
        X     = 16'd1080;
        Y     = 8'd12;
        start = 1'b1;
        repeat (5) @(posedge clk);
        pulseReset();
        repeat (20) @(posedge clk);
        #1;
        check("t5 no valid", 16'(valid), 16'd0);
        applyStimulus("t5", 16'd900, 8'd15, 17, 0);
        checkOutput("t5", 8'd60, 8'h00, 1'b0, 1'b0);

        // 6: handshake. Operand changes after the start edge are ignored.
        X = 16'h1234;
        Y = 8'h03;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("t6 hold", 8'd60, 8'h00, 1'b0, 1'b0);
        dropStart("t6");
        check("t6 Q kept", 16'(Q), 16'd60);
        check("t6 R kept", 16'(R), 16'd0);
        applyStimulus("t6 new", 16'hFFDB, 8'h07, 17, 0);
        checkOutput("t6 new", 8'hFB, 8'hFE, 1'b0, 1'b0);
        dropStart("t6 new");
        applyStimulus("t6 glitch", 16'h0438, 8'h0C, 17, 4);
        checkOutput("t6 glitch", 8'h5A, 8'h00, 1'b0, 1'b0);
        dropStart("t6 glitch");

        // Randomized operations, checked by the model every cycle.
        for (int i = 0; i < 150; i++) begin
            ry = 8'($urandom);
            if (i % 17 == 0) ry = 8'h00;
            if (i % 2 == 1) rx = 16'($urandom);
            else            rx = 16'($urandom_range(0, 4000)) - 16'd2000;
            applyStimulus("rand", rx, ry, (ry == 8'h00) ? 1 : 17, (i % 5 == 0) ? 7 : 0);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            dropStart("rand");
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
